// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with unified word memory and a machine-mode CSR subset.
// Latency: one instruction fetched, executed and retired per clk (CPI=1); memory reads are combinational.
// Backpressure: none; the core never stalls. Optional retirement trace when CORE_TRACE_EN is defined.

// Unified instruction/data memory: two combinational read ports, one byte-enabled write port.
module rv32i_mem #(
    parameter int MEM_WORDS = 65536,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] iaddr,
    output logic [31:0]   idata,
    input  logic [AW-1:0] daddr,
    output logic [31:0]   ddata,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata
);
    logic [31:0] m [0:MEM_WORDS-1];

    assign idata = m[iaddr];
    assign ddata = m[daddr];

    // Byte-lane write; lanes with we clear keep their old contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) m[daddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Architectural state, kept at top level for hierarchical inspection
    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic [31:0] inst, ld_word;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [11:0] csr_addr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] dat_addr, ld_sh, ld_val, st_dat;
    logic [31:0] op_b, alu_res, csr_old, csr_src;
    logic [4:0]  shamt;
    logic        br_taken;

    logic [31:0] next_pc, rd_val, csr_wval;
    logic [31:0] cause;
    logic        rd_we, csr_we, trap;
    logic [3:0]  st_be;

    logic        unused_bits;

    assign opcode   = inst[6:0];
    assign rd_idx   = inst[11:7];
    assign f3       = inst[14:12];
    assign rs1_idx  = inst[19:15];
    assign rs2_idx  = inst[24:20];
    assign csr_addr = inst[31:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // x0 always reads as zero regardless of array contents
    assign rs1_val  = (rs1_idx == 5'd0) ? 32'h0 : rs[rs1_idx];
    assign rs2_val  = (rs2_idx == 5'd0) ? 32'h0 : rs[rs2_idx];
    assign pc_plus4 = pc + 32'd4;

    // Loads and stores share the data port; only the immediate format differs
    assign dat_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign ld_sh    = ld_word >> {dat_addr[1:0], 3'b000};
    assign st_dat   = rs2_val << {dat_addr[1:0], 3'b000};

    assign csr_old = csr[csr_addr];
    assign csr_src = f3[2] ? {27'b0, rs1_idx} : rs1_val;

    assign op_b  = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt = op_b[4:0];

    assign unused_bits = ^{dat_addr[31:AW+2], ld_sh[31:16]};

    rv32i_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) memory (
        .clk   (clk),
        .iaddr (pc[AW+1:2]),
        .idata (inst),
        .daddr (dat_addr[AW+1:2]),
        .ddata (ld_word),
        .we    (st_be & {4{rst}}),
        .wdata (st_dat)
    );

    // ALU shared by OP and OP-IMM; inst[30] selects SUB (register form only) and SRA
    always_comb begin
        alu_res = 32'h0;
        case (f3)
            3'd0: alu_res = (opcode == OP_REG && inst[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'd1: alu_res = rs1_val << shamt;
            3'd2: alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'd3: alu_res = {31'b0, rs1_val < op_b};
            3'd4: alu_res = rs1_val ^ op_b;
            3'd5: alu_res = inst[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6: alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
    end

    // Branch condition and load extraction
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'd0: br_taken = (rs1_val == rs2_val);
            3'd1: br_taken = (rs1_val != rs2_val);
            3'd4: br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: br_taken = (rs1_val < rs2_val);
            3'd7: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
        ld_val = ld_word;
        case (f3)
            3'd0: ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'd1: ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'd4: ld_val = {24'b0, ld_sh[7:0]};
            3'd5: ld_val = {16'b0, ld_sh[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    // Main decode: next pc, writeback, store enables, CSR update and traps
    always_comb begin
        next_pc  = pc_plus4;
        rd_we    = 1'b0;
        rd_val   = 32'h0;
        st_be    = 4'b0000;
        csr_we   = 1'b0;
        csr_wval = csr_old;
        trap     = 1'b0;
        cause    = 32'h0;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'h1;
            end
            OP_BRANCH: if (br_taken) next_pc = pc + imm_b;
            OP_LOAD:   begin rd_we = 1'b1; rd_val = ld_val; end
            OP_STORE: begin
                case (f3)
                    3'd0:    st_be = 4'b0001 << dat_addr[1:0];
                    3'd1:    st_be = 4'b0011 << dat_addr[1:0];
                    default: st_be = 4'b1111;
                endcase
            end
            OP_IMM, OP_REG: begin rd_we = 1'b1; rd_val = alu_res; end
            OP_FENCE: ;
            OP_SYSTEM: begin
                if (f3 == 3'd0) begin
                    case (csr_addr)
                        12'h000: begin trap = 1'b1; cause = 32'd11; end
                        12'h001: begin trap = 1'b1; cause = 32'd3; end
                        12'h302: next_pc = csr[CSR_MEPC];
                        default: ;
                    endcase
                end else if (f3[1:0] != 2'b00) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    csr_we = (f3[1:0] == 2'b01) || (rs1_idx != 5'd0);
                    case (f3[1:0])
                        2'b01:   csr_wval = csr_src;
                        2'b10:   csr_wval = csr_old | csr_src;
                        default: csr_wval = csr_old & ~csr_src;
                    endcase
                end
            end
            default: begin trap = 1'b1; cause = 32'd2; end
        endcase
        if (trap) next_pc = csr[CSR_MTVEC] & ~32'h3;
    end

    // Commit pc, GPR and CSR updates on the same edge; reset leaves memory alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rs[i] <= 32'h0;
            csr[CSR_MSTATUS] <= 32'h0;
            csr[CSR_MTVEC]   <= 32'h0;
            csr[CSR_MEPC]    <= 32'h0;
            csr[CSR_MCAUSE]  <= 32'h0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd_idx != 5'd0) rs[rd_idx] <= rd_val;
            if (csr_we) csr[csr_addr] <= csr_wval;
            if (trap) begin
                csr[CSR_MEPC]   <= pc;
                csr[CSR_MCAUSE] <= cause;
            end
        end
    end

`ifdef CORE_TRACE_EN
    // Retirement trace, one line per executed instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            if (rd_we && rd_idx != 5'd0)
                $display("pc=%08h inst=%08h x%0d=%08h", pc, inst, rd_idx, rd_val);
            else
                $display("pc=%08h inst=%08h", pc, inst);
        end
    end
`endif
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: table of short programs plus hand-written multi-cycle sequences.
// Latency: checks sampled on the falling edge after each retiring rising edge.
// Backpressure: not applicable; the core runs one instruction per clock.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_core dut (.clk(clk), .rst(rst));

    int total = 0;
    int bad   = 0;
    logic [31:0] img [0:127];

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam logic [31:0] MRET  = 32'h3020_0073;

    function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 128; i++) img[i] = 32'h0;
    endtask

    // Hold reset, load the image, let two resetting edges pass
    task automatic boot();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) dut.memory.m[i] <= img[i];
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic go(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [31:0] i0, i1, i2, i3;
        int          rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{"addi_chain", e_i(12'd5, 0, 0, 1, 7'h13), e_i(12'hFF9, 1, 0, 2, 7'h13), NOP, NOP, 2, 32'hFFFF_FFFE};
        vecs[1]  = '{"addi_x1",    e_i(12'd5, 0, 0, 1, 7'h13), e_i(12'hFF9, 1, 0, 2, 7'h13), NOP, NOP, 1, 32'h0000_0005};
        vecs[2]  = '{"sra",  e_u(20'h80000, 1, 7'h37), e_i(12'd4, 0, 0, 2, 7'h13), e_r(7'h20, 2, 1, 5, 3), NOP, 3, 32'hF800_0000};
        vecs[3]  = '{"srl",  e_u(20'h80000, 1, 7'h37), e_i(12'd4, 0, 0, 2, 7'h13), e_r(7'h00, 2, 1, 5, 3), NOP, 3, 32'h0800_0000};
        vecs[4]  = '{"slt",  e_i(12'hFFF, 0, 0, 1, 7'h13), e_i(12'd1, 0, 0, 2, 7'h13), e_r(7'h00, 2, 1, 2, 3), NOP, 3, 32'h1};
        vecs[5]  = '{"sltu", e_i(12'hFFF, 0, 0, 1, 7'h13), e_i(12'd1, 0, 0, 2, 7'h13), e_r(7'h00, 2, 1, 3, 3), NOP, 3, 32'h0};
        vecs[6]  = '{"sub",  e_i(12'hFFF, 0, 0, 1, 7'h13), e_i(12'd1, 0, 0, 2, 7'h13), e_r(7'h20, 1, 2, 0, 3), NOP, 3, 32'h2};
        vecs[7]  = '{"x0_write", e_i(12'd1, 0, 0, 0, 7'h13), e_i(12'd1, 0, 0, 0, 7'h13), NOP, NOP, 0, 32'h0};
        vecs[8]  = '{"auipc", NOP, NOP, e_u(20'h00001, 3, 7'h17), NOP, 3, 32'h0000_1008};
        vecs[9]  = '{"xori", e_i(12'h0F0, 0, 0, 1, 7'h13), e_i(12'h0FF, 1, 4, 3, 7'h13), NOP, NOP, 3, 32'h0000_000F};
        vecs[10] = '{"slli", e_i(12'd3, 0, 0, 1, 7'h13), e_i(12'd31, 1, 1, 3, 7'h13), NOP, NOP, 3, 32'h8000_0000};
        // Branch at 0x4 jumps over 0x8 when taken: taken -> x3=2, not taken -> x3=3
        vecs[11] = '{"blt_taken",  e_i(12'hFFF, 0, 0, 1, 7'h13), e_b(13'd8, 0, 1, 4), e_i(12'd1, 0, 0, 3, 7'h13),
                     e_i(12'd2, 3, 0, 3, 7'h13), 3, 32'h2};
        vecs[12] = '{"bgeu_taken", e_i(12'hFFF, 0, 0, 1, 7'h13), e_b(13'd8, 0, 1, 7), e_i(12'd1, 0, 0, 3, 7'h13),
                     e_i(12'd2, 3, 0, 3, 7'h13), 3, 32'h2};
        vecs[13] = '{"bltu_not",   e_i(12'hFFF, 0, 0, 1, 7'h13), e_b(13'd8, 0, 1, 6), e_i(12'd1, 0, 0, 3, 7'h13),
                     e_i(12'd2, 3, 0, 3, 7'h13), 3, 32'h3};

        for (int v = 0; v < 14; v++) begin
            clear_img();
            img[0] = vecs[v].i0;
            img[1] = vecs[v].i1;
            img[2] = vecs[v].i2;
            img[3] = vecs[v].i3;
            boot();
            go(4);
            chk(vecs[v].name, dut.rs[vecs[v].rd], vecs[v].exp);
        end

        // Stores with byte enables, store-then-load forwarding across cycles, lane extraction
        clear_img();
        img[0] = e_i(12'd5, 0, 0, 1, 7'h13);
        img[1] = e_i(12'hFF9, 1, 0, 2, 7'h13);
        img[2] = e_s(12'h100, 2, 0, 2);
        img[3] = e_s(12'h101, 1, 0, 0);
        img[4] = e_i(12'h100, 0, 2, 3, 7'h03);
        img[5] = e_i(12'h100, 0, 0, 4, 7'h03);
        img[6] = e_i(12'h102, 0, 1, 5, 7'h03);
        img[7] = e_i(12'h101, 0, 5, 6, 7'h03);
        boot();
        chk("reset_pc", dut.pc, 32'h0);
        go(8);
        chk("lw_after_sb", dut.rs[3], 32'hFFFF_05FE);
        chk("lb",          dut.rs[4], 32'hFFFF_FFFE);
        chk("lh_hi",       dut.rs[5], 32'hFFFF_FFFF);
        chk("lhu_lane1",   dut.rs[6], 32'h0000_FF05);
        chk("mem_word",    dut.memory.m[64], 32'hFFFF_05FE);

        // Control flow: BEQ/BNE at 0x10/0x18, JAL at 0x20, JALR back
        clear_img();
        for (int i = 0; i < 4; i++) img[i] = NOP;
        img[4]  = e_b(13'd8, 0, 0, 0);
        img[6]  = e_b(13'd8, 0, 0, 1);
        img[7]  = NOP;
        img[8]  = e_j(21'd16, 1);
        img[12] = e_i(12'd1, 1, 0, 2, 7'h67);
        boot();
        go(5);
        chk("beq_taken", dut.pc, 32'h18);
        go(1);
        chk("bne_not", dut.pc, 32'h1C);
        go(2);
        chk("jal_pc", dut.pc, 32'h30);
        chk("jal_link", dut.rs[1], 32'h24);
        go(1);
        chk("jalr_pc", dut.pc, 32'h24);
        chk("jalr_link", dut.rs[2], 32'h34);

        // ECALL through mtvec, CSR read without write, MRET back to mepc
        clear_img();
        img[0]  = e_i(12'h040, 0, 0, 5, 7'h13);
        img[1]  = e_i(12'h305, 5, 1, 0, 7'h73);
        img[2]  = e_j(21'h58, 0);
        img[24] = ECALL;
        img[16] = e_i(12'h341, 0, 2, 6, 7'h73);
        img[17] = MRET;
        boot();
        go(3);
        chk("jal_to_ecall", dut.pc, 32'h60);
        go(1);
        chk("ecall_pc",     dut.pc, 32'h40);
        chk("ecall_mepc",   dut.csr[12'h341], 32'h60);
        chk("ecall_mcause", dut.csr[12'h342], 32'd11);
        chk("mtvec",        dut.csr[12'h305], 32'h40);
        go(1);
        chk("csrrs_read",   dut.rs[6], 32'h60);
        chk("csrrs_nowr",   dut.csr[12'h341], 32'h60);
        go(1);
        chk("mret_pc",      dut.pc, 32'h60);

        // Reset clears pc, GPRs and the trap CSRs
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc",     dut.pc, 32'h0);
        chk("rst_mtvec",  dut.csr[12'h305], 32'h0);
        chk("rst_mepc",   dut.csr[12'h341], 32'h0);
        chk("rst_mcause", dut.csr[12'h342], 32'h0);
        chk("rst_gpr",    dut.rs[6], 32'h0);

        // EBREAK then an illegal opcode trapping to itself
        clear_img();
        img[0]  = e_i(12'h080, 0, 0, 5, 7'h13);
        img[1]  = e_i(12'h305, 5, 1, 7, 7'h73);
        img[2]  = EBRK;
        img[32] = 32'hFFFF_FFFF;
        boot();
        go(2);
        chk("csrrw_old", dut.rs[7], 32'h0);
        go(1);
        chk("ebreak_pc",     dut.pc, 32'h80);
        chk("ebreak_mepc",   dut.csr[12'h341], 32'h8);
        chk("ebreak_mcause", dut.csr[12'h342], 32'd3);
        go(1);
        chk("illegal_pc",     dut.pc, 32'h80);
        chk("illegal_mepc",   dut.csr[12'h341], 32'h80);
        chk("illegal_mcause", dut.csr[12'h342], 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
